// File: rtl/pacman_pkg.sv
// pacman_pkg: direction encodings, FSM state type and direction helpers shared by the movement logic
package pacman_pkg;
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVING  = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    // Swaps left<->right and up<->down; 0 maps to 0.
    function automatic logic [3:0] opposite_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction
endpackage

// File: rtl/btn_edge_prio.sv
// btn_edge_prio: detects button rising edges and priority-encodes them (left>right>up>down)
//  clk, rst      clock, async active-high reset
//  btn[3:0]      synchronised button levels
//  press[3:0]    one-hot highest-priority new press, 0 if none
//  press_valid   1 when any button rose this cycle
module btn_edge_prio
    import pacman_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic [3:0] press,
    output logic       press_valid
);
    logic [3:0] btn_prev;
    logic [3:0] rise;

    always_ff @(posedge clk or posedge rst)
        if (rst) btn_prev <= '0;
        else     btn_prev <= btn;

    always_comb begin
        rise        = btn & ~btn_prev;
        press_valid = |rise;
        press       = rise[0] ? DIR_LEFT  :
                      rise[1] ? DIR_RIGHT :
                      rise[2] ? DIR_UP    :
                      rise[3] ? DIR_DOWN  : DIR_NONE;
    end
endmodule

// File: rtl/direction_ctrl.sv
// direction_ctrl: buffers turn requests, commits legal turns per frame and strobes one move per frame
//  clk, rst             clock, async active-high reset
//  frame_tick           one-cycle pulse per game frame
//  btn[3:0]             button levels [0]=left [1]=right [2]=up [3]=down
//  xpos, ypos           sprite position, used for tile alignment of perpendicular turns
//  legal_moves[3:0]     legality of each direction at the current position
//  curr_direction[3:0]  committed direction (one-hot or 0)
//  pending_dir[3:0]     buffered request (one-hot or 0)
//  move_en              one-cycle step strobe, the cycle after a frame_tick
//  blocked              committed direction is currently illegal
module direction_ctrl
    import pacman_pkg::*;
#(
    parameter int BUFFER_FRAMES = 8,
    parameter int TILE_BITS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] btn,
    input  logic [9:0] xpos,
    input  logic [9:0] ypos,
    input  logic [3:0] legal_moves,
    output logic [3:0] curr_direction,
    output logic [3:0] pending_dir,
    output logic       move_en,
    output logic       blocked
);
    localparam logic [9:0] TILE_MASK = 10'((1 << TILE_BITS) - 1);

    logic [3:0] press;
    logic       press_valid;
    state_t     state;
    logic [7:0] age;
    logic [7:0] age_n;
    logic       aligned;
    logic       do_commit;
    logic [3:0] d_next;

    btn_edge_prio u_edge (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .press       (press),
        .press_valid (press_valid)
    );

    always_comb begin
        aligned   = ((xpos | ypos) & TILE_MASK) == '0;
        // A legal pending request implies it is non-zero.
        do_commit = ((pending_dir & legal_moves) != '0) && (pending_dir != curr_direction) &&
                    ((curr_direction == DIR_NONE) || (pending_dir == opposite_dir(curr_direction)) || aligned);
        d_next    = do_commit ? pending_dir : curr_direction;
        age_n     = age + 8'd1;
    end

    assign blocked = (state == BLOCKED);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            curr_direction <= DIR_NONE;
            pending_dir    <= DIR_NONE;
            move_en        <= 1'b0;
            age            <= '0;
            state          <= IDLE;
        end else begin
            move_en <= 1'b0;
            if (frame_tick) begin
                curr_direction <= d_next;
                state   <= (d_next == DIR_NONE) ? IDLE : ((d_next & legal_moves) != '0) ? MOVING : BLOCKED;
                move_en <= (d_next & legal_moves) != '0;
                if (pending_dir != DIR_NONE) begin
                    age <= age_n;
                    if (do_commit || pending_dir == curr_direction || age_n >= 8'(BUFFER_FRAMES))
                        pending_dir <= DIR_NONE;
                end
            end
            // A fresh press wins over any clear or expiry in the same cycle.
            if (press_valid) begin
                pending_dir <= press;
                age         <= '0;
            end
        end
endmodule
